// File: rtl/present_key_sched_pkg.sv
// Shared definitions for the PRESENT key schedule: S-box table, widths, FSM states.
package present_key_sched_pkg;

    localparam int unsigned RK_W = 64;

    // PRESENT S-box, nibble i of the constant holds S(i).
    localparam logic [63:0] SBOX_TABLE = 64'h2174_8FE3_DA09_B65C;

    typedef enum logic [1:0] {
        StIdle,
        StGen,
        StFin
    } state_e;

    function automatic bit key_w_legal(input int unsigned w);
        return (w == 80) || (w == 128);
    endfunction

    function automatic logic [3:0] sbox_lookup(input logic [3:0] x);
        return SBOX_TABLE[{x, 2'b00} +: 4];
    endfunction

endpackage

// File: rtl/present_sbox.sv
// 4-bit PRESENT S-box, purely combinational.
module present_sbox
    import present_key_sched_pkg::*;
(
    input  logic [3:0] data_i,
    output logic [3:0] data_o
);

    assign data_o = sbox_lookup(data_i);

endmodule

// File: rtl/present_key_sched.sv
// PRESENT key schedule: streams NUM_ROUNDS+1 round keys with ready/valid and
// keeps a random-access copy of the last complete schedule.
module present_key_sched
    import present_key_sched_pkg::*;
#(
    parameter int unsigned KEY_W      = 80,
    parameter int unsigned NUM_ROUNDS = 31,
    // Wide enough to hold NUM_ROUNDS+1 and one index past it; never below 5 bits.
    localparam int unsigned IDX_W = ($clog2(NUM_ROUNDS + 3) > 5) ? $clog2(NUM_ROUNDS + 3) : 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [KEY_W-1:0] key_in,
    output logic             busy,
    output logic             rk_valid,
    input  logic             rk_ready,
    output logic [RK_W-1:0]  rk_data,
    output logic [IDX_W-1:0] rk_round,
    output logic             done,
    output logic             store_valid,
    input  logic [IDX_W-1:0] rd_idx,
    output logic [RK_W-1:0]  rd_key
);

    if (!key_w_legal(KEY_W)) begin : g_bad_key_w
        $error("present_key_sched: KEY_W must be 80 or 128");
    end

    localparam int unsigned    NUM_SBOX = (KEY_W == 128) ? 2 : 1;
    localparam int unsigned    CNT_LSB  = (KEY_W == 128) ? 62 : 15;
    localparam logic [IDX_W-1:0] LAST   = IDX_W'(NUM_ROUNDS + 1);

    state_e             state_q;
    logic [KEY_W-1:0]   key_q;
    logic [KEY_W-1:0]   key_d;
    logic [KEY_W-1:0]   key_rot;
    logic [IDX_W-1:0]   cnt_q;
    logic               busy_q;
    logic               valid_q;
    logic               done_q;
    logic               store_valid_q;
    logic [RK_W-1:0]    store_q [NUM_ROUNDS+2];
    logic [NUM_SBOX-1:0][3:0] sb_out;

    assign key_rot = {key_q[KEY_W-62:0], key_q[KEY_W-1:KEY_W-61]};

    for (genvar g = 0; g < NUM_SBOX; g++) begin : g_sbox
        present_sbox u_sbox (
            .data_i (key_rot[KEY_W-1-4*g -: 4]),
            .data_o (sb_out[g])
        );
    end

    // Next round key: rotated key with S-boxed top nibble(s) and round counter mixed in.
    always_comb begin
        key_d = key_rot;
        for (int g = 0; g < NUM_SBOX; g++) begin
            key_d[KEY_W-1-4*g -: 4] = sb_out[g];
        end
        key_d[CNT_LSB +: 5] = key_rot[CNT_LSB +: 5] ^ cnt_q[4:0];
    end

    // Control FSM with registered status outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= StIdle;
            key_q         <= '0;
            cnt_q         <= '0;
            busy_q        <= 1'b0;
            valid_q       <= 1'b0;
            done_q        <= 1'b0;
            store_valid_q <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        key_q         <= key_in;
                        cnt_q         <= IDX_W'(1);
                        store_valid_q <= 1'b0;
                        busy_q        <= 1'b1;
                        valid_q       <= 1'b1;
                        state_q       <= StGen;
                    end
                end
                StGen: begin
                    if (rk_ready) begin
                        if (cnt_q < LAST) begin
                            key_q <= key_d;
                            cnt_q <= cnt_q + IDX_W'(1);
                        end else begin
                            valid_q       <= 1'b0;
                            done_q        <= 1'b1;
                            store_valid_q <= 1'b1;
                            state_q       <= StFin;
                        end
                    end
                end
                StFin: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    // Key store: written on every accepted round key, deliberately not reset.
    always_ff @(posedge clk) begin
        if (rst_n && valid_q && rk_ready) begin
            store_q[cnt_q] <= key_q[KEY_W-1 -: RK_W];
        end
    end

    // Random-access read; index 0 and anything past the last round read as zero.
    always_comb begin
        rd_key = '0;
        if (rd_idx != '0 && rd_idx <= LAST) begin
            rd_key = store_q[rd_idx];
        end
    end

    assign busy        = busy_q;
    assign rk_valid    = valid_q;
    assign done        = done_q;
    assign store_valid = store_valid_q;
    assign rk_data     = valid_q ? key_q[KEY_W-1 -: RK_W] : '0;
    assign rk_round    = valid_q ? cnt_q : '0;

endmodule

// File: tb/tb_present_key_sched.sv
// Randomised bench for present_key_sched: KEY_W=80 and KEY_W=128 instances share
// the handshake and are checked every cycle against a schedule model.
module tb_present_key_sched;

    localparam int NR = 32;
    localparam logic [3:0] SB [16] = '{4'hC, 4'h5, 4'h6, 4'hB, 4'h9, 4'h0, 4'hA, 4'hD,
                                       4'h3, 4'hE, 4'hF, 4'h8, 4'h4, 4'h7, 4'h1, 4'h2};

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic         rk_ready = 1'b1;
    logic [5:0]   rd_idx = '0;
    logic [79:0]  key80 = '0;
    logic [127:0] key128 = '0;

    logic         busy80, valid80, done80, sv80;
    logic         busy128, valid128, done128, sv128;
    logic [63:0]  data80, data128, rd80, rd128;
    logic [5:0]   rnd80, rnd128;

    int vectors = 0;
    int miscompares = 0;
    int n_done = 0;
    int runs_done = 0;

    // Model state
    int           phase = 0;  // 0 idle, 1 streaming, 2 finishing
    int           idx = 0;
    bit           svalid = 1'b0;
    logic [63:0]  cur80 [1:NR];
    logic [63:0]  cur128 [1:NR];
    logic [63:0]  st80 [1:NR];
    logic [63:0]  st128 [1:NR];
    bit           known [1:NR];

    present_key_sched #(.KEY_W(80), .NUM_ROUNDS(31)) dut80 (
        .clk(clk), .rst_n(rst_n), .start(start), .key_in(key80), .busy(busy80),
        .rk_valid(valid80), .rk_ready(rk_ready), .rk_data(data80), .rk_round(rnd80),
        .done(done80), .store_valid(sv80), .rd_idx(rd_idx), .rd_key(rd80)
    );

    present_key_sched #(.KEY_W(128), .NUM_ROUNDS(31)) dut128 (
        .clk(clk), .rst_n(rst_n), .start(start), .key_in(key128), .busy(busy128),
        .rk_valid(valid128), .rk_ready(rk_ready), .rk_data(data128), .rk_round(rnd128),
        .done(done128), .store_valid(sv128), .rd_idx(rd_idx), .rd_key(rd128)
    );

    always #5 clk = ~clk;

    function automatic logic [127:0] next_key(input logic [127:0] k, input int w, input int rc);
        logic [127:0] mask;
        logic [127:0] r;
        mask = (w == 128) ? {128{1'b1}} : {48'd0, {80{1'b1}}};
        r = ((k << 61) | (k >> (w - 61))) & mask;
        if (w == 80) begin
            r[79:76] = SB[r[79:76]];
            r = r ^ (128'(rc) << 15);
        end else begin
            r[127:124] = SB[r[127:124]];
            r[123:120] = SB[r[123:120]];
            r = r ^ (128'(rc) << 62);
        end
        return r;
    endfunction

    function automatic logic [63:0] top64(input logic [127:0] k, input int w);
        return (w == 80) ? k[79:16] : k[127:64];
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // Scoreboard: compare every cycle, then advance the model by the inputs seen.
    initial begin : scoreboard
        logic [127:0] k80;
        logic [127:0] k128;
        @(posedge clk);
        forever begin
            @(negedge clk);
            chk("busy80", 128'(busy80), 128'(phase != 0));
            chk("busy128", 128'(busy128), 128'(phase != 0));
            chk("valid80", 128'(valid80), 128'(phase == 1));
            chk("valid128", 128'(valid128), 128'(phase == 1));
            chk("round80", 128'(rnd80), 128'((phase == 1) ? idx : 0));
            chk("round128", 128'(rnd128), 128'((phase == 1) ? idx : 0));
            chk("data80", 128'(data80), 128'((phase == 1) ? cur80[idx] : 64'd0));
            chk("data128", 128'(data128), 128'((phase == 1) ? cur128[idx] : 64'd0));
            chk("done80", 128'(done80), 128'(phase == 2));
            chk("done128", 128'(done128), 128'(phase == 2));
            chk("store_valid80", 128'(sv80), 128'(svalid));
            chk("store_valid128", 128'(sv128), 128'(svalid));
            if (rd_idx >= 1 && rd_idx <= NR) begin
                if (known[int'(rd_idx)]) begin
                    chk("rd_key80", 128'(rd80), 128'(st80[int'(rd_idx)]));
                    chk("rd_key128", 128'(rd128), 128'(st128[int'(rd_idx)]));
                end
            end else begin
                chk("rd_key80_oob", 128'(rd80), 128'(0));
                chk("rd_key128_oob", 128'(rd128), 128'(0));
            end
            if (done80) n_done++;

            if (!rst_n) begin
                phase  = 0;
                svalid = 1'b0;
            end else begin
                case (phase)
                    0: if (start) begin
                        k80  = 128'(key80);
                        k128 = key128;
                        for (int i = 1; i <= NR; i++) begin
                            cur80[i]  = top64(k80, 80);
                            cur128[i] = top64(k128, 128);
                            k80  = next_key(k80, 80, i);
                            k128 = next_key(k128, 128, i);
                        end
                        idx    = 1;
                        svalid = 1'b0;
                        phase  = 1;
                    end
                    1: if (rk_ready) begin
                        st80[idx]  = cur80[idx];
                        st128[idx] = cur128[idx];
                        known[idx] = 1'b1;
                        if (idx < NR) idx++;
                        else begin
                            phase  = 2;
                            svalid = 1'b1;
                        end
                    end
                    default: phase = 0;
                endcase
            end
        end
    end

    task automatic pulse_start(input logic [79:0] k8, input logic [127:0] k12);
        @(posedge clk); #1;
        key80  = k8;
        key128 = k12;
        start  = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic run_to_done(input int budget, input bit stall, input bit spam);
        int n = 0;
        while (!done80 && n < budget) begin
            @(posedge clk); #1;
            rk_ready = stall ? ($urandom_range(0, 3) != 0) : 1'b1;
            rd_idx   = 6'($urandom_range(0, 40));
            start    = spam ? 1'($urandom_range(0, 1)) : 1'b0;
            if (spam) key80 = 80'({$urandom(), $urandom(), $urandom()});
            n++;
        end
        start = 1'b0;
        if (!done80) begin
            vectors++;
            miscompares++;
            $display("FAIL done_timeout: no done within %0d cycles", budget);
        end else begin
            runs_done++;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            rd_idx = 6'($urandom_range(0, 40));
        end
    endtask

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        int n;
        for (int i = 1; i <= NR; i++) known[i] = 1'b0;

        // Model pins, hand-derived from the PRESENT update rule.
        chk("pin_k2_80", 128'(top64(next_key(128'd0, 80, 1), 80)), 128'(64'hC000_0000_0000_0000));
        chk("pin_k2_128", 128'(top64(next_key(128'd0, 128, 1), 128)),
            128'(64'hCC00_0000_0000_0000));
        chk("pin_k1_80_ones", 128'(top64({48'd0, {80{1'b1}}}, 80)),
            128'(64'hFFFF_FFFF_FFFF_FFFF));

        rst_n = 1'b0;
        idle(3);
        rst_n = 1'b1;
        idle(2);

        // Zero key, continuous ready: latency from start to done.
        rk_ready = 1'b1;
        pulse_start('0, '0);
        chk("k1_80_zero", 128'(data80), 128'(64'h0));
        n = 1;
        while (!done80 && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        chk("start_to_done", 128'(n), 128'(33));
        if (done80) runs_done++;
        idle(1);
        chk("k2_80_zero_model", 128'(cur80[2]), 128'(64'hC000_0000_0000_0000));
        chk("k2_128_zero_model", 128'(cur128[2]), 128'(64'hCC00_0000_0000_0000));
        for (int i = 0; i <= 33; i++) begin
            @(posedge clk); #1;
            rd_idx = 6'(i);
        end

        // All-ones 80-bit key with random stalls.
        pulse_start({80{1'b1}}, {$urandom(), $urandom(), $urandom(), $urandom()});
        chk("k1_80_ones", 128'(data80), 128'(64'hFFFF_FFFF_FFFF_FFFF));
        run_to_done(400, 1'b1, 1'b0);
        idle(3);

        // Reset partway through, then a fresh schedule.
        pulse_start(80'({$urandom(), $urandom(), $urandom()}),
                    {$urandom(), $urandom(), $urandom(), $urandom()});
        n = 0;
        while (rnd80 != 6'd10 && n < 400) begin
            @(posedge clk); #1;
            rk_ready = ($urandom_range(0, 3) != 0);
            rd_idx   = 6'($urandom_range(0, 40));
            n++;
        end
        chk("reached_round10", 128'(rnd80), 128'(10));
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n    = 1'b1;
        rk_ready = 1'b1;
        idle(4);
        pulse_start(80'({$urandom(), $urandom(), $urandom()}),
                    {$urandom(), $urandom(), $urandom(), $urandom()});
        run_to_done(400, 1'b1, 1'b0);
        idle(2);

        // start hammered while busy must be ignored.
        pulse_start(80'({$urandom(), $urandom(), $urandom()}),
                    {$urandom(), $urandom(), $urandom(), $urandom()});
        run_to_done(400, 1'b1, 1'b1);
        idle(3);

        // A few fully random schedules.
        for (int r = 0; r < 4; r++) begin
            pulse_start(80'({$urandom(), $urandom(), $urandom()}),
                        {$urandom(), $urandom(), $urandom(), $urandom()});
            run_to_done(400, r[0], 1'b0);
            idle($urandom_range(1, 4));
        end
        for (int i = 0; i <= 33; i++) begin
            @(posedge clk); #1;
            rd_idx = 6'(i);
        end
        idle(2);

        chk("done_count", 128'(n_done), 128'(runs_done));
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
